// File: rtl/disp_pkg.sv
// Shared display constants: blank pattern, scroll FSM encoding and active-low
// seven-segment glyphs (bit 7 = dp, bit 0 = segment a).
package disp_pkg;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [7:0] SSEG_0 = 8'hC0;
  localparam logic [7:0] SSEG_1 = 8'hF9;
  localparam logic [7:0] SSEG_2 = 8'hA4;
  localparam logic [7:0] SSEG_3 = 8'hB0;
  localparam logic [7:0] SSEG_4 = 8'h99;
  localparam logic [7:0] SSEG_5 = 8'h92;
  localparam logic [7:0] SSEG_6 = 8'h82;
  localparam logic [7:0] SSEG_7 = 8'hF8;
  localparam logic [7:0] SSEG_8 = 8'h80;
  localparam logic [7:0] SSEG_9 = 8'h90;
  localparam logic [7:0] SSEG_A = 8'h88;
  localparam logic [7:0] SSEG_B = 8'h83;
  localparam logic [7:0] SSEG_C = 8'hC6;
  localparam logic [7:0] SSEG_D = 8'hA1;
  localparam logic [7:0] SSEG_E = 8'h86;
  localparam logic [7:0] SSEG_F = 8'h8E;
  localparam logic [7:0] SSEG_H = 8'h89;
  localparam logic [7:0] SSEG_L = 8'hC7;
  localparam logic [7:0] SSEG_P = 8'h8C;

  function automatic logic [7:0] sseg_hex(input logic [3:0] v);
    case (v)
      4'h0: sseg_hex = SSEG_0;
      4'h1: sseg_hex = SSEG_1;
      4'h2: sseg_hex = SSEG_2;
      4'h3: sseg_hex = SSEG_3;
      4'h4: sseg_hex = SSEG_4;
      4'h5: sseg_hex = SSEG_5;
      4'h6: sseg_hex = SSEG_6;
      4'h7: sseg_hex = SSEG_7;
      4'h8: sseg_hex = SSEG_8;
      4'h9: sseg_hex = SSEG_9;
      4'hA: sseg_hex = SSEG_A;
      4'hB: sseg_hex = SSEG_B;
      4'hC: sseg_hex = SSEG_C;
      4'hD: sseg_hex = SSEG_D;
      4'hE: sseg_hex = SSEG_E;
      default: sseg_hex = SSEG_F;
    endcase
  endfunction

endpackage

// File: rtl/scroll_tick.sv
// Divide-by-DIV counter with enable and sync clear; pulse is high combinationally
// during the enabled cycle in which the count sits at DIV-1.
module scroll_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic pulse
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [TW-1:0] tick;

  assign pulse = en && (tick == TW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
    end else if (clr) begin
      tick <= '0;
    end else if (en) begin
      tick <= pulse ? '0 : tick + TW'(1);
    end
  end

endmodule

// File: rtl/disp_scroll_ctrl.sv
// Message buffer plus right-to-left scroll sequencer feeding the 4-digit mux.
// Define DISP_SCROLL_LOOP_EN to repeat the message until stop instead of a single pass.
module disp_scroll_ctrl
  import disp_pkg::*;
#(
  parameter int MSG_LEN    = 16,
  parameter int SCROLL_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       clear,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic       busy,
  output logic       done,
  output logic [7:0] in0,
  output logic [7:0] in1,
  output logic [7:0] in2,
  output logic [7:0] in3
);

  localparam int PW = $clog2(MSG_LEN + 5);
  localparam int CW = $clog2(MSG_LEN + 1);
  localparam int IW = PW + 2;
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   pos, pos_nxt;
  logic [CW-1:0]   cnt;
  logic            done_nxt;
  logic [7:0]      msg_buf [MSG_LEN];
  logic            tick_en, tick_clr, tick_pulse;
  logic            wr_acc;
  logic [IW-1:0]   end_pos, pos_inc, k, off;
  logic [7:0]      win [4];

  assign busy     = (state != IDLE);
  assign wr_ready = (state == IDLE) && (cnt < CW'(MSG_LEN));
  assign wr_acc   = wr_en && wr_ready && !clear;

  // Counting runs from PAUSE too, so the release cycle itself counts.
  assign tick_en  = busy && !stop && !pause;
  assign tick_clr = !busy || stop;

  assign end_pos = IW'(cnt) + IW'(4);
  assign pos_inc = IW'(pos) + IW'(1);

  scroll_tick #(.DIV(SCROLL_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (tick_clr),
    .pulse (tick_pulse)
  );

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && (cnt != '0) && !stop) begin
          state_nxt = RUN;
          pos_nxt   = '0;
        end
      end
      RUN, PAUSE: begin
        if (stop) begin
          state_nxt = IDLE;
          pos_nxt   = '0;
        end else if (pause) begin
          state_nxt = PAUSE;
        end else begin
          state_nxt = RUN;
          if (tick_pulse) begin
            if (pos_inc == end_pos) begin
              pos_nxt = '0;
`ifdef DISP_SCROLL_LOOP_EN
              state_nxt = RUN;
`else
              state_nxt = IDLE;
              done_nxt  = 1'b1;
`endif
            end else begin
              pos_nxt = pos_inc[PW-1:0];
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        pos_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pos   <= '0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      done  <= done_nxt;
      if (state == IDLE && clear) begin
        cnt <= '0;
      end else if (wr_acc) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      msg_buf[cnt[AW-1:0]] <= wr_data;
    end
  end

  // Window over the virtual sequence: 4 leading blanks, message, trailing blanks.
  always_comb begin
    k   = '0;
    off = '0;
    for (int d = 0; d < 4; d++) begin
      win[d] = SSEG_BLANK;
      k      = IW'(pos) + IW'(d);
      if (k >= IW'(4) && k < end_pos) begin
        off    = k - IW'(4);
        win[d] = msg_buf[off[AW-1:0]];
      end
    end
  end

  assign in3 = win[0];
  assign in2 = win[1];
  assign in1 = win[2];
  assign in0 = win[3];

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Directed bench for disp_scroll_ctrl (SCROLL_DIV=4, MSG_LEN=16) with a per-cycle
// expected-output scoreboard built from an independent window model.
module tb_disp_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, clear, start, pause, stop;
  logic [7:0] wr_data;
  logic       wr_ready, busy, done;
  logic [7:0] in0, in1, in2, in3;

  disp_scroll_ctrl #(.MSG_LEN(16), .SCROLL_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .clear    (clear),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .busy     (busy),
    .done     (done),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [34:0] v;
  } exp_t;

  exp_t       q[$];
  logic [7:0] msg [16];
  int         mcnt = 0;
  int         cyc  = 0;
  int         nchk = 0;
  int         npass = 0;
  int         nfail = 0;
  int         t0;

  localparam logic [34:0] IDLE_V = {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};

  function automatic logic [34:0] obs();
    return {in3, in2, in1, in0, busy, done, wr_ready};
  endfunction

  function automatic logic [7:0] vseq(input int kk);
    if (kk >= 4 && kk < 4 + mcnt) return msg[kk-4];
    return 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [34:0] o, input logic [34:0] e);
    nchk++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, o, e);
    end
  endtask

  // Expected outputs for offsets 0..jmax after the start-accept edge t0;
  // pause is held for pl edges following offset ps.
  task automatic push_scroll(input int ts, input int ps, input int pl, input int jmax);
    for (int j = 0; j <= jmax; j++) begin
      int   je, p, tot;
      logic b, dn;
      exp_t e;
      je  = (j <= ps) ? j : ((j <= ps + pl) ? ps : j - pl);
      tot = 4 * (mcnt + 4);
`ifdef DISP_SCROLL_LOOP_EN
      p  = (je / 4) % (mcnt + 4);
      b  = 1'b1;
      dn = 1'b0;
`else
      if (je < tot) begin
        p = je / 4; b = 1'b1; dn = 1'b0;
      end else begin
        p = 0; b = 1'b0; dn = (je == tot);
      end
`endif
      e.cyc = ts + j;
      e.v   = {vseq(p), vseq(p+1), vseq(p+2), vseq(p+3), b, dn, (!b && mcnt < 16)};
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk((e.cyc == cyc) ? "scroll" : "missed", obs(), e.v);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (mcnt < 16) begin
      msg[mcnt] = d;
      mcnt++;
    end
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic full_scroll();
    t0 = cyc + 1;
    push_scroll(t0, 99, 0, 4 * (mcnt + 4) + 1);
    go();
    repeat (4 * (mcnt + 4) + 1) tick();
    chk("drain", 35'(q.size()), 35'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cyc=%0d required <20000", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; clear = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", obs(), IDLE_V);
    rst_n = 1'b1;
    tick();
    chk("idle", obs(), IDLE_V);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_empty", obs(), IDLE_V);

`ifndef DISP_SCROLL_LOOP_EN
    // Three-character single pass.
    wr(8'h88); wr(8'h83); wr(8'hC6);
    full_scroll();

    // Pause for 10 cycles after the first shift; writes/clear ignored meanwhile.
    t0 = cyc + 1;
    push_scroll(t0, 4, 10, 39);
    go();
    repeat (4) tick();
    pause = 1'b1; wr_en = 1'b1; wr_data = 8'h00; clear = 1'b1;
    repeat (10) tick();
    pause = 1'b0; wr_en = 1'b0; clear = 1'b0;
    repeat (25) tick();
    chk("pause_drain", 35'(q.size()), 35'd0);

    // stop together with start mid-scroll, then replay from the beginning.
    t0 = cyc + 1;
    push_scroll(t0, 99, 0, 9);
    go();
    repeat (9) tick();
    for (int j = 10; j <= 15; j++) begin
      exp_t e;
      e.cyc = t0 + j;
      e.v   = IDLE_V;
      q.push_back(e);
    end
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    repeat (5) tick();
    chk("stop_drain", 35'(q.size()), 35'd0);
    full_scroll();

    // clear beats a simultaneous write; then overfill the buffer.
    clear = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    tick();
    clear = 1'b0; wr_en = 1'b0;
    mcnt = 0;
    chk("clear", obs(), IDLE_V);
    for (int i = 0; i < 17; i++) begin
      wr(8'h10 + 8'(i));
      if (i == 15) chk("full_rdy", 35'(wr_ready), 35'd0);
    end
    full_scroll();
`endif

    // One character: loops (when enabled) then reset asserted mid-run.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mcnt = 0;
    wr(8'h89);
    t0 = cyc + 1;
`ifdef DISP_SCROLL_LOOP_EN
    push_scroll(t0, 99, 0, 45);
    go();
    repeat (45) tick();
`else
    push_scroll(t0, 99, 0, 9);
    go();
    repeat (9) tick();
`endif
    chk("loop_drain", 35'(q.size()), 35'd0);
    rst_n = 1'b0;
    #1;
    mcnt = 0;
    chk("rst_mid", obs(), IDLE_V);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst", obs(), IDLE_V);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
